// File: rtl/operand_io_pkg.sv
// Shared types and sizing for the FPU lab operand/result I/O sequencer.
// SEQ_TIMEOUT_EN selects the WAIT_DONE timeout and ERR state in the sequencer.
package operand_io_pkg;

    localparam int DATA_W      = 32;
    localparam int BYTE_W      = 8;
    localparam int NBYTES      = DATA_W / BYTE_W;
    localparam int IDX_W       = $clog2(NBYTES);
    localparam int TIMEOUT_CYC = 1024;
    localparam int CNT_W       = $clog2(TIMEOUT_CYC + 1);

    localparam logic [DATA_W-1:0] ERR_RESULT = {DATA_W{1'b1}};

    typedef enum logic [2:0] {
        LOAD_A    = 3'd0,
        LOAD_B    = 3'd1,
        START     = 3'd2,
        WAIT_DONE = 3'd3,
        SHOW_R    = 3'd4,
        ERR       = 3'd5
    } seq_state_t;

endpackage

// File: rtl/operand_io_sequencer_edge.sv
// Rising-edge detector for the synchronised enter button.
// Produces a single-cycle epulse per press regardless of hold time.
module enter_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic enter,
    output logic epulse
);

    logic enter_q;
    logic enter_d;

    always_comb begin
        enter_d = enter;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enter_q <= 1'b0;
        end else begin
            enter_q <= enter_d;
        end
    end

    assign epulse = enter & ~enter_q;

endmodule

// File: rtl/operand_io_sequencer.sv
// Byte-wise operand loader, FPU launch handshake and result byte display.
// Define SEQ_TIMEOUT_EN to add the WAIT_DONE timeout and ERR state.
import operand_io_pkg::*;

module operand_io_sequencer (
    input  logic              clk,
    input  logic              reset,
    input  logic              enter,
    input  logic [BYTE_W-1:0] inputdata,
    input  logic              loaddata,
    input  logic              op_done,
    input  logic [DATA_W-1:0] op_result,
    output logic              op_start,
    output logic [DATA_W-1:0] dataA,
    output logic [DATA_W-1:0] dataB,
    output logic [DATA_W-1:0] dataR,
    output logic              inputdata_ready,
    output logic              op_error,
    output logic [BYTE_W-1:0] disp_byte,
    output logic [1:0]        disp_idx,
    output logic [2:0]        state_o
);

    seq_state_t        state_q, state_d;
    logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic [IDX_W-1:0]  disp_idx_q, disp_idx_d;
    logic [DATA_W-1:0] data_a_q, data_a_d;
    logic [DATA_W-1:0] data_b_q, data_b_d;
    logic [DATA_W-1:0] data_r_q, data_r_d;
    logic              ready_q, ready_d;
    logic              op_start_c;
    logic [BYTE_W-1:0] disp_byte_c;
    logic              epulse;
    logic              last_byte;

`ifdef SEQ_TIMEOUT_EN
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              error_q, error_d;
`endif

    enter_edge_det u_edge (
        .clk    (clk),
        .reset  (reset),
        .enter  (enter),
        .epulse (epulse)
    );

    assign last_byte = (byte_idx_q == IDX_W'(NBYTES - 1));

    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        disp_idx_d  = disp_idx_q;
        data_a_d    = data_a_q;
        data_b_d    = data_b_q;
        data_r_d    = data_r_q;
        ready_d     = ready_q;
        op_start_c  = 1'b0;
        disp_byte_c = '0;
`ifdef SEQ_TIMEOUT_EN
        cnt_d       = cnt_q;
        error_d     = error_q;
`endif
        unique case (state_q)
            LOAD_A: begin
                disp_byte_c = inputdata;
                if (epulse && loaddata) begin
                    data_a_d[byte_idx_q*BYTE_W +: BYTE_W] = inputdata;
                    byte_idx_d = last_byte ? '0 : byte_idx_q + 1'b1;
                    if (last_byte) state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                disp_byte_c = inputdata;
                if (epulse && loaddata) begin
                    data_b_d[byte_idx_q*BYTE_W +: BYTE_W] = inputdata;
                    byte_idx_d = last_byte ? '0 : byte_idx_q + 1'b1;
                    if (last_byte) state_d = START;
                end
            end
            START: begin
                op_start_c = 1'b1;
                ready_d    = 1'b1;
                state_d    = WAIT_DONE;
`ifdef SEQ_TIMEOUT_EN
                cnt_d      = '0;
`endif
            end
            WAIT_DONE: begin
                // op_done takes priority over an expiring timeout
                if (op_done) begin
                    data_r_d   = op_result;
                    disp_idx_d = '0;
                    state_d    = SHOW_R;
`ifdef SEQ_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    data_r_d   = ERR_RESULT;
                    error_d    = 1'b1;
                    disp_idx_d = '0;
                    state_d    = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            SHOW_R, ERR: begin
                disp_byte_c = data_r_q[disp_idx_q*BYTE_W +: BYTE_W];
                if (epulse) begin
                    if (loaddata) begin
                        // restart press doubles as A byte 0
                        state_d              = LOAD_A;
                        ready_d              = 1'b0;
                        data_a_d[BYTE_W-1:0] = inputdata;
                        byte_idx_d           = IDX_W'(1);
`ifdef SEQ_TIMEOUT_EN
                        error_d              = 1'b0;
`endif
                    end else begin
                        disp_idx_d = disp_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = LOAD_A;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= LOAD_A;
            byte_idx_q <= '0;
            disp_idx_q <= '0;
            data_a_q   <= '0;
            data_b_q   <= '0;
            data_r_q   <= '0;
            ready_q    <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            cnt_q      <= '0;
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            disp_idx_q <= disp_idx_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            data_r_q   <= data_r_d;
            ready_q    <= ready_d;
`ifdef SEQ_TIMEOUT_EN
            cnt_q      <= cnt_d;
            error_q    <= error_d;
`endif
        end
    end

`ifdef SEQ_TIMEOUT_EN
    assign op_error = error_q;
`else
    assign op_error = 1'b0;
`endif

    assign op_start        = op_start_c;
    assign dataA           = data_a_q;
    assign dataB           = data_b_q;
    assign dataR           = data_r_q;
    assign inputdata_ready = ready_q;
    assign disp_byte       = disp_byte_c;
    assign disp_idx        = disp_idx_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_operand_io_sequencer.sv
// Directed bench for operand_io_sequencer with a byte-array reference model.
// Define SEQ_TIMEOUT_EN to also exercise the timeout path.
module tb_operand_io_sequencer;

    localparam int S_LA = 0, S_LB = 1, S_ST = 2, S_WT = 3, S_SH = 4, S_ER = 5;
    localparam int TOUT = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enter = 1'b0;
    logic [7:0]  inputdata = 8'h00;
    logic        loaddata = 1'b0;
    logic        op_done = 1'b0;
    logic [31:0] op_result = 32'h0;
    logic        op_start;
    logic [31:0] dataA, dataB, dataR;
    logic        inputdata_ready;
    logic        op_error;
    logic [7:0]  disp_byte;
    logic [1:0]  disp_idx;
    logic [2:0]  state_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_io_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .enter           (enter),
        .inputdata       (inputdata),
        .loaddata        (loaddata),
        .op_done         (op_done),
        .op_result       (op_result),
        .op_start        (op_start),
        .dataA           (dataA),
        .dataB           (dataB),
        .dataR           (dataR),
        .inputdata_ready (inputdata_ready),
        .op_error        (op_error),
        .disp_byte       (disp_byte),
        .disp_idx        (disp_idx),
        .state_o         (state_o)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: operands kept as byte arrays, mode as a plain int.
    logic [7:0] ma[4] = '{default: 8'h00};
    logic [7:0] mb[4] = '{default: 8'h00};
    logic [7:0] mr[4] = '{default: 8'h00};
    int mode = S_LA, bidx = 0, didx = 0, wcnt = 0;
    bit mready = 0, merr = 0, mprev = 0, ep;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mode = S_LA; bidx = 0; didx = 0; wcnt = 0;
            mready = 0; merr = 0; mprev = 0;
            for (int i = 0; i < 4; i++) begin
                ma[i] = 8'h00; mb[i] = 8'h00; mr[i] = 8'h00;
            end
        end else begin
            ep = enter && !mprev;
            mprev = enter;
            case (mode)
                S_LA, S_LB: if (ep && loaddata) begin
                    if (mode == S_LA) ma[bidx] = inputdata;
                    else mb[bidx] = inputdata;
                    if (bidx == 3) begin
                        bidx = 0;
                        mode = (mode == S_LA) ? S_LB : S_ST;
                    end else bidx++;
                end
                S_ST: begin mready = 1; wcnt = 0; mode = S_WT; end
                S_WT: begin
                    if (op_done) begin
                        for (int i = 0; i < 4; i++) mr[i] = op_result[i*8 +: 8];
                        didx = 0; mode = S_SH;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (wcnt == TOUT - 1) begin
                        for (int i = 0; i < 4; i++) mr[i] = 8'hFF;
                        merr = 1; didx = 0; mode = S_ER;
                    end else wcnt++;
`endif
                end
                S_SH, S_ER: if (ep) begin
                    if (loaddata) begin
                        mode = S_LA; mready = 0; merr = 0;
                        ma[0] = inputdata; bidx = 1;
                    end else didx = (didx + 1) % 4;
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [7:0] eb;
        case (mode)
            S_LA, S_LB: eb = inputdata;
            S_SH, S_ER: eb = mr[didx];
            default:    eb = 8'h00;
        endcase
        chk("state", {29'd0, state_o}, mode);
        chk("dataA", dataA, {ma[3], ma[2], ma[1], ma[0]});
        chk("dataB", dataB, {mb[3], mb[2], mb[1], mb[0]});
        chk("dataR", dataR, {mr[3], mr[2], mr[1], mr[0]});
        chk("op_start", {31'd0, op_start}, (mode == S_ST) ? 1 : 0);
        chk("ready", {31'd0, inputdata_ready}, {31'd0, mready});
        chk("op_error", {31'd0, op_error}, {31'd0, merr});
        chk("disp_byte", {24'd0, disp_byte}, {24'd0, eb});
        chk("disp_idx", {30'd0, disp_idx}, didx);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] d, input logic ld);
        inputdata = d; loaddata = ld; enter = 1'b1;
        tick();
        enter = 1'b0;
        tick();
    endtask

    // last B byte: op_start must be high in the cycle right after the edge
    task automatic press_last(input logic [7:0] d);
        inputdata = d; loaddata = 1'b1; enter = 1'b1;
        tick();
        chk("op_start_lat", {31'd0, op_start}, 32'd1);
        enter = 1'b0;
        tick();
        chk("op_start_one", {31'd0, op_start}, 32'd0);
        chk("wait_state", {29'd0, state_o}, S_WT);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n = 0;
        while (state_o !== s && n < budget) begin
            tick();
            n++;
        end
        chk("wait_bound", {29'd0, state_o}, {29'd0, s});
    endtask

    initial begin
        int eidx[4] = '{1, 2, 3, 0};
        logic [7:0] ebyte[4] = '{8'h00, 8'h00, 8'h40, 8'h00};

        repeat (3) tick();
        chk("rst_state", {29'd0, state_o}, S_LA);
        chk("rst_dataA", dataA, 32'h0);
        chk("rst_ready", {31'd0, inputdata_ready}, 32'd0);
        chk("rst_start", {31'd0, op_start}, 32'd0);
        reset = 1'b0;
        tick();

        press(8'h00, 1); press(8'h00, 1); press(8'h80, 1); press(8'h3F, 1);
        press(8'h7D, 1); press(8'h86, 1); press(8'hBE, 1);
        press_last(8'hA1);
        chk("t1_dataA", dataA, 32'h3F80_0000);
        chk("t1_dataB", dataB, 32'hA1BE_867D);
        chk("t1_ready", {31'd0, inputdata_ready}, 32'd1);

        repeat (3) tick();
        op_result = 32'h4000_0000; op_done = 1'b1;
        tick();
        op_done = 1'b0;
        chk("t2_state", {29'd0, state_o}, S_SH);
        chk("t2_dataR", dataR, 32'h4000_0000);
        chk("t2_disp0", {24'd0, disp_byte}, 32'h00);
        for (int i = 0; i < 4; i++) begin
            press(8'hC3, 0);
            chk("t2_idx", {30'd0, disp_idx}, eidx[i]);
            chk("t2_byte", {24'd0, disp_byte}, {24'd0, ebyte[i]});
        end

        press(8'h55, 1);
        chk("t4_state", {29'd0, state_o}, S_LA);
        chk("t4_dataA", dataA, 32'h3F80_0055);
        chk("t4_ready", {31'd0, inputdata_ready}, 32'd0);
        chk("t4_dataB", dataB, 32'hA1BE_867D);
        press(8'h77, 0);
        chk("ld0_ignored", dataA, 32'h3F80_0055);
        op_result = 32'h1234_5678; op_done = 1'b1;
        tick();
        op_done = 1'b0;
        chk("stray_done", dataR, 32'h4000_0000);

        inputdata = 8'h11; loaddata = 1'b1; enter = 1'b1;
        repeat (10) tick();
        enter = 1'b0;
        tick();
        chk("t3_hold", dataA, 32'h3F80_1155);
        press(8'h22, 1);
        chk("t3_next", dataA, 32'h3F22_1155);
        press(8'h33, 1);
        chk("t3_last", dataA, 32'h3322_1155);
        chk("t3_toB", {29'd0, state_o}, S_LB);
        press(8'h01, 1); press(8'h02, 1); press(8'h03, 1);
        press_last(8'h04);
        chk("t3_dataB", dataB, 32'h0403_0201);
        press(8'h99, 1);
        chk("wait_ignA", dataA, 32'h3322_1155);
        chk("wait_ignB", dataB, 32'h0403_0201);
        chk("wait_stay", {29'd0, state_o}, S_WT);

        reset = 1'b1;
        #1;
        chk("t5_state", {29'd0, state_o}, S_LA);
        chk("t5_dataA", dataA, 32'h0);
        chk("t5_dataB", dataB, 32'h0);
        chk("t5_ready", {31'd0, inputdata_ready}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        op_result = 32'hDEAD_BEEF; op_done = 1'b1;
        tick();
        op_done = 1'b0;
        chk("t5_late_done", dataR, 32'h0);
        chk("t5_still_A", {29'd0, state_o}, S_LA);

`ifdef SEQ_TIMEOUT_EN
        for (int i = 0; i < 7; i++) press(8'(i + 1), 1);
        press_last(8'hF0);
        wait_state(3'(S_ER), TOUT + 20);
        chk("t6_error", {31'd0, op_error}, 32'd1);
        chk("t6_dataR", dataR, 32'hFFFF_FFFF);
        press(8'h66, 1);
        chk("t6_clear", {31'd0, op_error}, 32'd0);
        chk("t6_state", {29'd0, state_o}, S_LA);
`else
        for (int i = 0; i < 7; i++) press(8'(i + 1), 1);
        press_last(8'hF0);
        repeat (40) tick();
        chk("no_timeout", {31'd0, op_error}, 32'd0);
        op_result = 32'h0BAD_F00D; op_done = 1'b1;
        tick();
        op_done = 1'b0;
        wait_state(3'(S_SH), 5);
        chk("late_result", dataR, 32'h0BAD_F00D);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
